// File: rtl/btn_event_ctrl.sv
// Multi-channel push-button front end: sync, debounce, and gesture
// classification into short press, double click and long press events.
module btn_event_ctrl #(
    parameter int                  CLK_FREQUENCY   = 48000000,
    parameter int                  NUM_BTNS        = 1,
    parameter logic [NUM_BTNS-1:0] BTN_ACTIVE_MASK = '1,
    parameter int                  DEBOUNCE_MS     = 10,
    parameter int                  LONG_PRESS_MS   = 1000,
    parameter int                  DOUBLE_CLICK_MS = 300
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] usr_btn,
    output logic [NUM_BTNS-1:0] pressed,
    output logic [NUM_BTNS-1:0] short_press,
    output logic [NUM_BTNS-1:0] double_click,
    output logic [NUM_BTNS-1:0] long_press,
    output logic [NUM_BTNS-1:0] long_hold
);

    localparam int DB_CLKS =
        int'((longint'(CLK_FREQUENCY) * DEBOUNCE_MS + 999) / 1000);
    localparam int LP_CLKS =
        int'((longint'(CLK_FREQUENCY) * LONG_PRESS_MS + 999) / 1000);
    localparam int DC_CLKS =
        int'((longint'(CLK_FREQUENCY) * DOUBLE_CLICK_MS + 999) / 1000);
    localparam int T_MAX = (LP_CLKS > DC_CLKS) ? LP_CLKS : DC_CLKS;
    localparam int DBW   = $clog2(DB_CLKS + 1);
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CLKS - 1);
    localparam logic [TW-1:0]  LP_LAST = TW'(LP_CLKS - 1);
    localparam logic [TW-1:0]  DC_LAST = TW'(DC_CLKS - 1);
    localparam logic [TW-1:0]  T_SAT   = TW'(T_MAX);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_2ND,
        PRESSED_2,
        LONG
    } state_t;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        logic [1:0]     sync_q, sync_d;
        logic           btn_act;
        logic [DBW-1:0] db_cnt_q, db_cnt_d;
        logic           prs_q, prs_d;
        state_t         st_q, st_d;
        logic [TW-1:0]  tmr_q, tmr_d;
        logic           sp_q, sp_d;
        logic           dc_q, dc_d;
        logic           lp_q, lp_d;
        logic           lh_q, lh_d;

        always_comb begin
            sync_d   = {sync_q[0], usr_btn[i]};
            btn_act  = sync_q[1] ^ ~BTN_ACTIVE_MASK[i];
            prs_d    = prs_q;
            db_cnt_d = '0;
            if (btn_act != prs_q) begin
                if (db_cnt_q == DB_LAST) begin
                    prs_d = ~prs_q;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end
        end

        // The FSM reacts to the debounced edge in the same cycle it lands.
        always_comb begin
            st_d  = st_q;
            sp_d  = 1'b0;
            dc_d  = 1'b0;
            lp_d  = 1'b0;
            tmr_d = (tmr_q == T_SAT) ? tmr_q : tmr_q + TW'(1);
            unique case (st_q)
                IDLE: begin
                    if (prs_d) st_d = PRESSED;
                end
                PRESSED: begin
                    if (tmr_q == LP_LAST) begin
                        lp_d = 1'b1;
                        st_d = LONG;
                    end else if (!prs_d) begin
                        st_d = WAIT_2ND;
                    end
                end
                WAIT_2ND: begin
                    if (prs_d) begin
                        st_d = PRESSED_2;
                    end else if (tmr_q == DC_LAST) begin
                        sp_d = 1'b1;
                        st_d = IDLE;
                    end
                end
                PRESSED_2: begin
                    if (tmr_q == LP_LAST) begin
                        lp_d = 1'b1;
                        st_d = LONG;
                    end else if (!prs_d) begin
                        dc_d = 1'b1;
                        st_d = IDLE;
                    end
                end
                LONG: begin
                    if (!prs_d) st_d = IDLE;
                end
                default: st_d = IDLE;
            endcase
            if (st_d != st_q) tmr_d = '0;
            lh_d = (st_d == LONG);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q   <= {2{~BTN_ACTIVE_MASK[i]}};
                db_cnt_q <= '0;
                prs_q    <= 1'b0;
                st_q     <= IDLE;
                tmr_q    <= '0;
                sp_q     <= 1'b0;
                dc_q     <= 1'b0;
                lp_q     <= 1'b0;
                lh_q     <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                db_cnt_q <= db_cnt_d;
                prs_q    <= prs_d;
                st_q     <= st_d;
                tmr_q    <= tmr_d;
                sp_q     <= sp_d;
                dc_q     <= dc_d;
                lp_q     <= lp_d;
                lh_q     <= lh_d;
            end
        end

        assign pressed[i]      = prs_q;
        assign short_press[i]  = sp_q;
        assign double_click[i] = dc_q;
        assign long_press[i]   = lp_q;
        assign long_hold[i]    = lh_q;
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: 1 clk = 1 ms, DB=4, LP=40, DC=20,
// ch0 active-high, ch1 active-low.
module tb_btn_event_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] usr_btn;
    logic [1:0] pressed;
    logic [1:0] short_press;
    logic [1:0] double_click;
    logic [1:0] long_press;
    logic [1:0] long_hold;

    btn_event_ctrl #(
        .CLK_FREQUENCY  (1000),
        .NUM_BTNS       (2),
        .BTN_ACTIVE_MASK(2'b01),
        .DEBOUNCE_MS    (4),
        .LONG_PRESS_MS  (40),
        .DOUBLE_CLICK_MS(20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .usr_btn     (usr_btn),
        .pressed     (pressed),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .long_hold   (long_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] btn;
        int         n;
        logic [1:0] prs;
        logic [1:0] sp;
        logic [1:0] dc;
        logic [1:0] lp;
        logic [1:0] lh;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    int checks;
    int errors;
    int cyc;
    int sp_n[2], dc_n[2], lp_n[2], lh_n[2];
    int sp_at[2], dc_at[2], lp_at[2];
    int rise_at[2], fall_at[2];
    logic [1:0] prs_prev;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {pressed, short_press, double_click, long_press, long_hold};
    endfunction

    task automatic clr();
        for (int c = 0; c < 2; c++) begin
            sp_n[c] = 0; dc_n[c] = 0; lp_n[c] = 0; lh_n[c] = 0;
            sp_at[c] = -1; dc_at[c] = -1; lp_at[c] = -1;
            rise_at[c] = -1; fall_at[c] = -1;
        end
        prs_prev = pressed;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (short_press[c] === 1'b1) begin sp_n[c]++; sp_at[c] = cyc; end
            if (double_click[c] === 1'b1) begin dc_n[c]++; dc_at[c] = cyc; end
            if (long_press[c] === 1'b1) begin lp_n[c]++; lp_at[c] = cyc; end
            if (long_hold[c] === 1'b1) lh_n[c]++;
            if (pressed[c] && !prs_prev[c]) rise_at[c] = cyc;
            if (!pressed[c] && prs_prev[c]) fall_at[c] = cyc;
        end
        prs_prev = pressed;
    endtask

    task automatic run(input logic [1:0] b, input int n);
        usr_btn = b;
        repeat (n) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n   = 1'b0;
        usr_btn = 2'b10;

        // glitch, short press on ch0, then long press on ch1
        vt[0]  = '{2'b11,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[1]  = '{2'b10,  8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[2]  = '{2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[3]  = '{2'b11,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[4]  = '{2'b11,  4, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[5]  = '{2'b10,  5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[6]  = '{2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[7]  = '{2'b10, 19, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[8]  = '{2'b10,  1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vt[9]  = '{2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[10] = '{2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[11] = '{2'b00,  1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[12] = '{2'b00, 39, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[13] = '{2'b00,  1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10};
        vt[14] = '{2'b00, 14, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        vt[15] = '{2'b10,  5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        vt[16] = '{2'b10,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[17] = '{2'b10, 30, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        clr();
        run(2'b10, 10);
        chk("post_reset_outs", 32'(outs()), 32'h0);
        chk("post_reset_evts", sp_n[0] + dc_n[0] + lp_n[0] + sp_n[1]
            + dc_n[1] + lp_n[1], 0);

        clr();
        for (int i = 0; i < NV; i++) begin
            run(vt[i].btn, vt[i].n);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vt[i].prs, vt[i].sp, vt[i].dc, vt[i].lp, vt[i].lh}));
        end
        chk("tbl_sp0_n", sp_n[0], 1);
        chk("tbl_sp0_lat", sp_at[0] - fall_at[0], 20);
        chk("tbl_lp1_n", lp_n[1], 1);
        chk("tbl_lp1_lat", lp_at[1] - rise_at[1], 40);
        chk("tbl_lh1_len", lh_n[1], 20);
        chk("tbl_other", sp_n[1] + dc_n[0] + dc_n[1] + lp_n[0], 0);

        // double click then a third click
        clr();
        run(2'b11, 8); run(2'b10, 8); run(2'b11, 8); run(2'b10, 30);
        chk("dbl_dc_n", dc_n[0], 1);
        chk("dbl_dc_at", dc_at[0] - fall_at[0], 0);
        chk("dbl_sp_lp", sp_n[0] + lp_n[0], 0);
        run(2'b11, 8); run(2'b10, 30);
        chk("third_sp_n", sp_n[0], 1);
        chk("third_dc_n", dc_n[0], 1);

        // gap equal to the window: press wins over timeout
        clr();
        run(2'b11, 8); run(2'b10, 20); run(2'b11, 8); run(2'b10, 30);
        chk("gap20_dc", dc_n[0], 1);
        chk("gap20_sp", sp_n[0], 0);

        // gap one past the window: two single clicks
        clr();
        run(2'b11, 8); run(2'b10, 21); run(2'b11, 8); run(2'b10, 30);
        chk("gap21_sp", sp_n[0], 2);
        chk("gap21_dc", dc_n[0], 0);

        // release on the threshold cycle: long press wins
        clr();
        run(2'b11, 40); run(2'b10, 30);
        chk("hold40_lp", lp_n[0], 1);
        chk("hold40_sp_dc", sp_n[0] + dc_n[0], 0);
        chk("hold40_lh", lh_n[0], 1);

        clr();
        run(2'b11, 39); run(2'b10, 30);
        chk("hold39_lp", lp_n[0], 0);
        chk("hold39_sp", sp_n[0], 1);

        // ch0 double click overlapping ch1 long press
        clr();
        run(2'b00, 5); run(2'b01, 8); run(2'b00, 8); run(2'b01, 8);
        run(2'b00, 31); run(2'b10, 30);
        chk("ind_dc0", dc_n[0], 1);
        chk("ind_dc0_at", dc_at[0] - fall_at[0], 0);
        chk("ind_other0", sp_n[0] + lp_n[0] + lh_n[0], 0);
        chk("ind_lp1", lp_n[1], 1);
        chk("ind_lp1_lat", lp_at[1] - rise_at[1], 40);
        chk("ind_lh1", lh_n[1], 20);
        chk("ind_other1", sp_n[1] + dc_n[1], 0);

        // reset while ch0 waits for a second click and ch1 holds long
        clr();
        run(2'b00, 35); run(2'b01, 8); run(2'b00, 10);
        chk("pre_rst_prs", 32'(pressed), 32'h2);
        chk("pre_rst_lh", 32'(long_hold), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(outs()), 32'h0);
        usr_btn = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr();
        run(2'b10, 40);
        chk("rst_no_sp", sp_n[0], 0);
        chk("rst_prs", 32'(pressed), 32'h0);
        chk("rst_evts", dc_n[0] + lp_n[0] + sp_n[1] + dc_n[1] + lp_n[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Multi-channel push-button front end that replaces single-button reset/boot detection.
- Per channel: synchronises the raw button and debounces it.
- Classifies each gesture as short press, double click or long press.
- Events are single-cycle pulses for downstream reset, boot and user-mode logic; a level output indicates an ongoing long hold.

Parameters:
- CLK_FREQUENCY, 48000000, clock frequency in Hz.
- NUM_BTNS, 1, number of independent button channels.
- BTN_ACTIVE_MASK, all ones (NUM_BTNS bits), per-channel pressed level (bit=1: active-high, bit=0: active-low).
- DEBOUNCE_MS, 10, time the input must be stable before the debounced state changes.
- LONG_PRESS_MS, 1000, hold time that produces a long press.
- DOUBLE_CLICK_MS, 300, maximum release-to-second-press gap for a double click.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- usr_btn  input  NUM_BTNS  raw asynchronous button inputs.
- pressed  output  NUM_BTNS  debounced state, 1 = pressed, polarity-normalised.
- short_press  output  NUM_BTNS  1-cycle pulse per single click.
- double_click  output  NUM_BTNS  1-cycle pulse per double click.
- long_press  output  NUM_BTNS  1-cycle pulse when hold time is reached.
- long_hold  output  NUM_BTNS  high from the long_press pulse until release.

Behaviour:
- Derived counts:
  - DB_CLKS = ceil(CLK_FREQUENCY/1000*DEBOUNCE_MS).
  - LP_CLKS = ceil(CLK_FREQUENCY/1000*LONG_PRESS_MS).
  - DC_CLKS = ceil(CLK_FREQUENCY/1000*DOUBLE_CLICK_MS).
  - Counter widths are $clog2(count+1); counters never wrap.
- Reset (rst_n low, any time):
  - All outputs go to 0 and every FSM goes to IDLE.
  - Synchroniser flops load the channel's released level, so releasing reset never generates a false press.
- Synchroniser: 2 flops per channel; the XOR with ~BTN_ACTIVE_MASK normalises the input to active-high.
- Debounce:
  - The counter clears whenever the synchronised input equals pressed; otherwise it increments.
  - When it reaches DB_CLKS, pressed toggles and the counter clears.
  - A glitch shorter than DB_CLKS cycles changes nothing.
  - A clean edge updates pressed DB_CLKS+2 cycles after the input edge.
- Gesture FSM per channel, driven by the debounced press/release. The timer clears on every state change.
  - IDLE: on press, go to PRESSED.
  - PRESSED: on release before timer==LP_CLKS-1, go to WAIT_2ND. When the timer reaches LP_CLKS-1 while still held, pulse long_press and go to LONG.
  - WAIT_2ND: on press before timer==DC_CLKS-1, go to PRESSED_2. On timeout, pulse short_press and go to IDLE.
  - PRESSED_2: on release, pulse double_click and go to IDLE. If held to LP_CLKS-1, pulse long_press, go to LONG, and suppress double_click.
  - LONG: long_hold=1; on release, go to IDLE with no further pulse.
- Event outputs are registered and asserted for exactly the cycle after the deciding transition edge.
- At most one event pulse per channel per gesture.
- Simultaneous events:
  - If release and the long-press threshold occur in the same cycle, long press wins.
  - If a press and the WAIT_2ND timeout occur in the same cycle, the press wins (double-click path).
  - A third click arriving after a double click begins a fresh gesture from IDLE.
- Channels are fully independent; no cross-channel arbitration.

Test Plan:
Bench configuration: CLK_FREQUENCY=1000 (1 clk = 1 ms), DEBOUNCE_MS=4, LONG_PRESS_MS=40, DOUBLE_CLICK_MS=20, NUM_BTNS=2, BTN_ACTIVE_MASK=2'b01 (ch1 active-low, idles high).
- Glitch: ch0 high for 3 clks, then low -> pressed[0] stays 0 and no events; hold 4+ clks -> pressed[0] rises 6 clks after the edge.
- Short: ch0 held 10 clks, released -> exactly one short_press[0] pulse 20 clks after debounced release; no other events.
- Double: ch0 press 8, release 8, press 8, release -> one double_click[0] pulse the cycle after the second debounced release; short_press never asserts.
- Long: ch1 driven low for 60 clks -> long_press[1] pulse 40 clks after debounced press; long_hold[1] high until debounced release; no event on release.
- Independence: ch0 double click overlapping a ch1 long press -> both event sets exact, no cross-talk.
- Reset mid-gesture: assert rst_n low while ch0 is in WAIT_2ND -> outputs 0 immediately; after release with the button idle, no short_press emitted and pressed=0.
